key_seq_transmitter: RTL

- Downstream consumer of the input-key decoder's Active/Mode outputs.
- Once the key sequence unlocks the design (Active=1), this block accepts parallel data words over a valid/ready handshake and serialises them on a one-bit output stream.
- Mode selects bit order; an optional even-parity bit is appended.
- Nothing is transmitted while locked (Active=0).

---
 rtl/key_seq_transmitter_if.sv | 26 ++
 rtl/key_seq_transmitter.sv | 79 +++++++
 2 files changed

// File: rtl/key_seq_transmitter_if.sv
// Word-input and serial-output signal bundle for key_seq_transmitter.
// master drives the word side and observes the stream; slave is the transmitter.
interface key_seq_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Active;
    logic                  Mode;
    logic [DATA_WIDTH-1:0] InData;
    logic                  InValid;
    logic                  InReady;
    logic                  TxBit;
    logic                  TxValid;
    logic                  TxLast;
    logic                  Busy;
    logic                  Done;

    modport master (
        output Active, Mode, InData, InValid,
        input  InReady, TxBit, TxValid, TxLast, Busy, Done
    );

    modport slave (
        input  Active, Mode, InData, InValid,
        output InReady, TxBit, TxValid, TxLast, Busy, Done
    );
endinterface

// File: rtl/key_seq_transmitter.sv
// Serialises handshaken parallel words onto a one-bit stream once the key decoder
// reports Active; Mode picks LSB/MSB-first and an even-parity bit may follow the data.
module key_seq_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    key_seq_transmitter_if.slave bus,
    output logic [1:0]           dbg_state
);
    // Handshake: a word moves on a rising Clk edge where InValid and InReady are
    // both high; InReady never depends on InValid, and InData is ignored otherwise.
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  mode_q;
    logic                  par_acc;
    logic                  cur_bit;
    logic                  in_ready;

    assign cur_bit  = mode_q ? shreg[DATA_WIDTH-1] : shreg[0];
    assign in_ready = bus.Active && (state == IDLE) && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            par_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.InValid && in_ready) begin
                        shreg   <= bus.InData;
                        mode_q  <= bus.Mode;
                        cnt     <= '0;
                        par_acc <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The bit on the wire this cycle is folded into parity as it leaves.
                    par_acc <= par_acc ^ cur_bit;
                    shreg   <= mode_q ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[DATA_WIDTH-1:1]};
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        state <= (PARITY_EN != 0) ? PARITY : DONE;
                    end
                end
                PARITY: state <= DONE;
                DONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.InReady = in_ready;
    assign bus.TxValid = (state == SHIFT) || (state == PARITY);
    assign bus.TxBit   = (state == SHIFT)  ? cur_bit :
                         (state == PARITY) ? par_acc : 1'b0;
    assign bus.TxLast  = (PARITY_EN != 0) ? (state == PARITY)
                                          : ((state == SHIFT) && (cnt == LAST_IDX));
    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = (state == DONE);
    assign dbg_state   = state;
endmodule
